// File: rtl/uivid_pkg.sv
// Shared definitions for the video pattern generator and the stream monitor:
// lock state encoding, grid pattern constants and the default 720p geometry.
package uivid_pkg;

   typedef enum logic [1:0] {
      SEARCH  = 2'd0,
      MEASURE = 2'd1,
      LOCKED  = 2'd2
   } mon_state_t;

   localparam int          GRID_BIT   = 4;
   localparam logic [23:0] GRID_BLACK = 24'h000000;
   localparam logic [23:0] GRID_WHITE = 24'hFFFFFF;

   localparam int DEF_H_ACT = 1280;
   localparam int DEF_V_ACT = 720;
   localparam int DEF_H_TOT = 1650;
   localparam int DEF_V_TOT = 750;

   // Cells whose x/y cell indices differ in parity are black.
   function automatic logic [23:0] grid_pixel(input logic x_cell, input logic y_cell);
      return (x_cell ^ y_cell) ? GRID_BLACK : GRID_WHITE;
   endfunction

endpackage

// File: rtl/uivid_edge.sv
// Registers one sync bit and reports its rising and falling edges
// against the live input.
module uivid_edge (
   input  logic clk,
   input  logic rst_n,
   input  logic sync,
   output logic rise,
   output logic fall
);

   logic sync_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_reg <= 1'b0;
      end else begin
         sync_reg <= sync;
      end
   end

   assign rise = ~sync_reg & sync;
   assign fall = sync_reg & ~sync;

endmodule

// File: rtl/uivmon.sv
// Sink-side video monitor: measures frame geometry, locks after two matching
// frames and counts pixel mismatches against the 16x16 black/white grid.
module uivmon
   import uivid_pkg::*;
#(
   parameter int EXP_H_ACT = DEF_H_ACT,
   parameter int EXP_V_ACT = DEF_V_ACT,
   parameter int CNT_W     = 12,
   parameter int ERR_W     = 16
) (
   input  logic             mon_clk_i,
   input  logic             mon_rstn_i,
   input  logic             mon_vs_i,
   input  logic             mon_hs_i,
   input  logic             mon_de_i,
   input  logic [23:0]      mon_data_i,
   input  logic             chk_en_i,
   input  logic             err_clr_i,
   output logic [CNT_W-1:0] h_act_o,
   output logic [CNT_W-1:0] v_act_o,
   output logic [CNT_W-1:0] h_tot_o,
   output logic [CNT_W-1:0] v_tot_o,
   output logic [15:0]      frame_cnt_o,
   output logic             frame_done_o,
   output logic             lock_o,
   output logic             fmt_ok_o,
   output logic [ERR_W-1:0] err_cnt_o
);

   localparam logic [CNT_W-1:0] EXP_H   = CNT_W'(EXP_H_ACT);
   localparam logic [CNT_W-1:0] EXP_V   = CNT_W'(EXP_V_ACT);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [ERR_W-1:0] ERR_ONE = ERR_W'(1);

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_ONE;
   endfunction

   // Edge detection for vs (bit 0), hs (bit 1) and de (bit 2).
   logic [2:0] sync_in;
   logic [2:0] edge_rise;
   logic [2:0] edge_fall;
   assign sync_in = {mon_de_i, mon_hs_i, mon_vs_i};

   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_edge
         uivid_edge u_edge (
            .clk   (mon_clk_i),
            .rst_n (mon_rstn_i),
            .sync  (sync_in[gi]),
            .rise  (edge_rise[gi]),
            .fall  (edge_fall[gi])
         );
      end
   endgenerate

   logic vs_rise;
   logic hs_rise;
   logic de_fall;
   logic unused_edges;
   assign vs_rise      = edge_rise[0];
   assign hs_rise      = edge_rise[1];
   assign de_fall      = edge_fall[2];
   assign unused_edges = edge_rise[2] | edge_fall[0] | edge_fall[1];

   logic [CNT_W-1:0] hpix_reg;
   logic [CNT_W-1:0] hclk_reg;
   logic [CNT_W-1:0] vline_reg;
   logic [CNT_W-1:0] vhs_reg;
   logic [CNT_W-1:0] sh_h_act_reg;
   logic [CNT_W-1:0] sh_h_tot_reg;

   always_ff @(posedge mon_clk_i or negedge mon_rstn_i) begin
      if (!mon_rstn_i) begin
         hpix_reg     <= '0;
         hclk_reg     <= '0;
         vline_reg    <= '0;
         vhs_reg      <= '0;
         sh_h_act_reg <= '0;
         sh_h_tot_reg <= '0;
      end else begin
         if (de_fall) begin
            hpix_reg     <= '0;
            sh_h_act_reg <= hpix_reg;
         end else if (mon_de_i) begin
            hpix_reg <= sat_inc(hpix_reg);
         end

         if (hs_rise) begin
            sh_h_tot_reg <= hclk_reg;
            hclk_reg     <= CNT_ONE;
         end else begin
            hclk_reg <= sat_inc(hclk_reg);
         end

         // An hs rise coincident with vs rise is the new frame's first line.
         if (vs_rise) begin
            vline_reg <= '0;
            vhs_reg   <= hs_rise ? CNT_ONE : '0;
         end else begin
            if (de_fall) begin
               vline_reg <= sat_inc(vline_reg);
            end
            if (hs_rise) begin
               vhs_reg <= sat_inc(vhs_reg);
            end
         end
      end
   end

   // Geometry of the ending frame, including a line or line total that
   // completes in the same cycle as the vs rise.
   logic [CNT_W-1:0] cur_h_act;
   logic [CNT_W-1:0] cur_v_act;
   logic [CNT_W-1:0] cur_h_tot;
   logic [CNT_W-1:0] cur_v_tot;
   logic             geom_same;
   logic             fmt_match;

   assign cur_h_act = de_fall ? hpix_reg : sh_h_act_reg;
   assign cur_v_act = de_fall ? sat_inc(vline_reg) : vline_reg;
   assign cur_h_tot = hs_rise ? hclk_reg : sh_h_tot_reg;
   assign cur_v_tot = vhs_reg;

   logic [CNT_W-1:0] h_act_reg;
   logic [CNT_W-1:0] v_act_reg;
   logic [CNT_W-1:0] h_tot_reg;
   logic [CNT_W-1:0] v_tot_reg;
   logic [15:0]      frame_cnt_reg;
   logic             frame_done_reg;
   logic             lock_reg;
   logic             fmt_ok_reg;
   mon_state_t       state_reg;

   assign geom_same = (cur_h_act == h_act_reg) && (cur_v_act == v_act_reg) &&
                      (cur_h_tot == h_tot_reg) && (cur_v_tot == v_tot_reg);
   assign fmt_match = (cur_h_act == EXP_H) && (cur_v_act == EXP_V);

   always_ff @(posedge mon_clk_i or negedge mon_rstn_i) begin
      if (!mon_rstn_i) begin
         state_reg      <= SEARCH;
         h_act_reg      <= '0;
         v_act_reg      <= '0;
         h_tot_reg      <= '0;
         v_tot_reg      <= '0;
         frame_cnt_reg  <= '0;
         frame_done_reg <= 1'b0;
         lock_reg       <= 1'b0;
         fmt_ok_reg     <= 1'b0;
      end else begin
         frame_done_reg <= 1'b0;
         if (vs_rise) begin
            case (state_reg)
               SEARCH: state_reg <= MEASURE;
               MEASURE, LOCKED: begin
                  h_act_reg      <= cur_h_act;
                  v_act_reg      <= cur_v_act;
                  h_tot_reg      <= cur_h_tot;
                  v_tot_reg      <= cur_v_tot;
                  frame_cnt_reg  <= frame_cnt_reg + 16'd1;
                  frame_done_reg <= 1'b1;
                  // A locked set always has nonzero v_act, so one test serves both states.
                  if (geom_same && (cur_v_act != '0)) begin
                     state_reg  <= LOCKED;
                     lock_reg   <= 1'b1;
                     fmt_ok_reg <= fmt_match;
                  end else begin
                     state_reg  <= MEASURE;
                     lock_reg   <= 1'b0;
                     fmt_ok_reg <= 1'b0;
                  end
               end
               default: state_reg <= SEARCH;
            endcase
         end
      end
   end

   logic [ERR_W-1:0] err_reg;
   logic             chk_active;
   logic             pix_bad;

   assign chk_active = (state_reg == LOCKED) && chk_en_i && mon_de_i;
   assign pix_bad    = mon_data_i != grid_pixel(hpix_reg[GRID_BIT], vline_reg[GRID_BIT]);

   always_ff @(posedge mon_clk_i or negedge mon_rstn_i) begin
      if (!mon_rstn_i) begin
         err_reg <= '0;
      end else if (err_clr_i) begin
         err_reg <= '0;
      end else if (chk_active && pix_bad && !(&err_reg)) begin
         err_reg <= err_reg + ERR_ONE;
      end
   end

   assign h_act_o      = h_act_reg;
   assign v_act_o      = v_act_reg;
   assign h_tot_o      = h_tot_reg;
   assign v_tot_o      = v_tot_reg;
   assign frame_cnt_o  = frame_cnt_reg;
   assign frame_done_o = frame_done_reg;
   assign lock_o       = lock_reg;
   assign fmt_ok_o     = fmt_ok_reg;
   assign err_cnt_o    = err_reg;

endmodule

// File: tb/tb_uivmon.sv
// Directed bench for uivmon on a reduced 40x20 geometry; frame reports are
// predicted into a scoreboard queue and compared when frame_done pulses.
module tb_uivmon;

   localparam int H_ACT = 40;
   localparam int V_ACT = 20;
   localparam int H_TOT = 50;
   localparam int V_TOT = 24;
   localparam int CNT_W = 12;
   localparam int ERR_W = 4;
   localparam int ERR_MAX = 15;
   localparam int CNT_MAX = 4095;

   logic              mon_clk  = 1'b0;
   logic              mon_rstn = 1'b1;
   logic              vs = 1'b0;
   logic              hs = 1'b0;
   logic              de = 1'b0;
   logic [23:0]       data = 24'h0;
   logic              chk_en = 1'b0;
   logic              err_clr = 1'b0;
   logic [CNT_W-1:0]  h_act, v_act, h_tot, v_tot;
   logic [15:0]       frame_cnt;
   logic              frame_done, lock, fmt_ok;
   logic [ERR_W-1:0]  err_cnt;

   uivmon #(
      .EXP_H_ACT (H_ACT),
      .EXP_V_ACT (V_ACT),
      .CNT_W     (CNT_W),
      .ERR_W     (ERR_W)
   ) dut (
      .mon_clk_i    (mon_clk),
      .mon_rstn_i   (mon_rstn),
      .mon_vs_i     (vs),
      .mon_hs_i     (hs),
      .mon_de_i     (de),
      .mon_data_i   (data),
      .chk_en_i     (chk_en),
      .err_clr_i    (err_clr),
      .h_act_o      (h_act),
      .v_act_o      (v_act),
      .h_tot_o      (h_tot),
      .v_tot_o      (v_tot),
      .frame_cnt_o  (frame_cnt),
      .frame_done_o (frame_done),
      .lock_o       (lock),
      .fmt_ok_o     (fmt_ok),
      .err_cnt_o    (err_cnt)
   );

   always #5 mon_clk = ~mon_clk;

   int checks   = 0;
   int failures = 0;
   int cyc_cnt  = 0;
   always @(posedge mon_clk) cyc_cnt <= cyc_cnt + 1;

   typedef struct {
      int h_act; int v_act; int h_tot; int v_tot; int fcnt;
      bit lock;  bit fmt;   int cyc;
   } exp_t;
   exp_t sb_q[$];

   // Reference model state: 0 search, 1 measure, 2 locked.
   int m_state = 0;
   int prev_hact = 0, prev_vact = 0, prev_htot = 0, prev_vtot = 0;
   int pend_hact = 0, pend_vact = 0, pend_htot = 0, pend_vtot = 0;
   int m_fcnt = 0;
   int m_err  = 0;
   bit clr_req = 1'b0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge mon_clk);
      #1;
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_h_act"}, h_act, 0);
      check({tag, "_v_act"}, v_act, 0);
      check({tag, "_h_tot"}, h_tot, 0);
      check({tag, "_v_tot"}, v_tot, 0);
      check({tag, "_frame_cnt"}, frame_cnt, 0);
      check({tag, "_frame_done"}, frame_done, 0);
      check({tag, "_lock"}, lock, 0);
      check({tag, "_fmt_ok"}, fmt_ok, 0);
      check({tag, "_err_cnt"}, err_cnt, 0);
   endtask

   // Called in the cycle that drives a vs rise; predicts the report.
   task automatic model_vs_rise();
      exp_t e;
      bit   same;
      if (m_state == 0) begin
         m_state = 1;
         return;
      end
      same = (pend_hact == prev_hact) && (pend_vact == prev_vact) &&
             (pend_htot == prev_htot) && (pend_vtot == prev_vtot);
      prev_hact = pend_hact; prev_vact = pend_vact;
      prev_htot = pend_htot; prev_vtot = pend_vtot;
      m_fcnt = (m_fcnt + 1) & 16'hFFFF;
      m_state = (same && pend_vact != 0) ? 2 : 1;
      e.h_act = pend_hact; e.v_act = pend_vact;
      e.h_tot = pend_htot; e.v_tot = pend_vtot;
      e.fcnt  = m_fcnt;
      e.lock  = (m_state == 2);
      e.fmt   = e.lock && (pend_hact == H_ACT) && (pend_vact == V_ACT);
      e.cyc   = cyc_cnt + 1;
      sb_q.push_back(e);
   endtask

   task automatic do_reset();
      mon_rstn = 1'b0;
      #1;
      check_zero("rst_mid");
      m_state = 0; m_fcnt = 0; m_err = 0;
      prev_hact = 0; prev_vact = 0; prev_htot = 0; prev_vtot = 0;
      repeat (3) tick();
      mon_rstn = 1'b1;
   endtask

   task automatic send_frame(input int hact, input int vact, input bit tail,
                             input int cx, input int cy, input bit clr_on_bad,
                             input bit all_wrong, input int rst_line);
      for (int l = 0; l < V_TOT; l++) begin
         for (int c = 0; c < H_TOT; c++) begin
            bit act, hit;
            int x, y;
            logic [23:0] expd;
            act = 1'b0; x = 0; y = 0; expd = 24'h0;
            vs = (l < 2);
            hs = (c < 4);
            err_clr = 1'b0;
            if (l >= 2 && l < 2 + vact && c >= 10 && c < 10 + hact) begin
               act = 1'b1; x = c - 10; y = l - 2;
            end
            if (tail && l == V_TOT - 1 && c >= H_TOT - hact) begin
               act = 1'b1; x = c - (H_TOT - hact); y = vact;
            end
            de = act;
            if (l == 0 && c == 0) model_vs_rise();
            if (l == 0 && c == 5 && clr_req) begin
               err_clr = 1'b1; clr_req = 1'b0; m_err = 0;
            end
            hit = act && (x == cx) && (y == cy);
            if (act) begin
               expd = (((x >> 4) ^ (y >> 4)) & 1) != 0 ? 24'h000000 : 24'hFFFFFF;
               data = all_wrong ? ~expd : (hit ? 24'h123456 : expd);
               if (m_state == 2 && chk_en && data != expd)
                  m_err = (m_err == ERR_MAX) ? ERR_MAX : m_err + 1;
            end else begin
               data = 24'h0;
            end
            if (hit && clr_on_bad) begin
               err_clr = 1'b1; m_err = 0;
            end
            tick();
            if (hit) check(clr_on_bad ? "err_clr_vs_bad" : "err_after_bad", err_cnt, m_err);
            if (l == rst_line && c == 20) do_reset();
         end
      end
      err_clr = 1'b0;
      pend_hact = hact; pend_vact = vact + int'(tail);
      pend_htot = H_TOT; pend_vtot = V_TOT;
      check("err_frame_end", err_cnt, m_err);
      check("lock_frame_end", lock, m_state == 2);
   endtask

   task automatic frames(input int n, input int hact);
      for (int i = 0; i < n; i++) send_frame(hact, V_ACT, 1'b0, -1, -1, 1'b0, 1'b0, -1);
   endtask

   // Lines with no vs at all; hs period of 4 clocks.
   task automatic send_stretch(input int n);
      vs = 1'b0; de = 1'b0; data = 24'h0; err_clr = 1'b0;
      for (int i = 0; i < n; i++) begin
         for (int c = 0; c < 4; c++) begin
            hs = (c == 0);
            tick();
            if (i == n / 2 && c == 0) check("lock_hold_no_vs", lock, m_state == 2);
         end
      end
      pend_htot = 4;
      pend_vtot = (V_TOT + n > CNT_MAX) ? CNT_MAX : V_TOT + n;
   endtask

   always @(negedge mon_clk) begin : sb_monitor
      exp_t e;
      if (sb_q.size() != 0 && cyc_cnt >= sb_q[0].cyc) begin
         e = sb_q.pop_front();
         check("frame_done", frame_done, 1);
         check("h_act", h_act, e.h_act);
         check("v_act", v_act, e.v_act);
         check("h_tot", h_tot, e.h_tot);
         check("v_tot", v_tot, e.v_tot);
         check("frame_cnt", frame_cnt, e.fcnt);
         check("lock", lock, e.lock);
         check("fmt_ok", fmt_ok, e.fmt);
      end else begin
         check("frame_done_idle", frame_done, 0);
      end
   end

   initial begin
      #2;
      mon_rstn = 1'b0;
      #1;
      check_zero("reset");
      repeat (3) tick();
      mon_rstn = 1'b1;
      chk_en = 1'b1;

      frames(3, H_ACT);                                            // lock
      send_frame(H_ACT, V_ACT, 1'b0, 17, 3, 1'b0, 1'b0, -1);       // single error
      send_frame(H_ACT, V_ACT, 1'b0, 17, 3, 1'b1, 1'b0, -1);       // clear beats error
      chk_en = 1'b0;
      send_frame(H_ACT, V_ACT, 1'b0, -1, -1, 1'b0, 1'b1, -1);      // check disabled
      chk_en = 1'b1;
      send_frame(H_ACT, V_ACT, 1'b0, -1, -1, 1'b0, 1'b1, -1);      // saturate at 15
      clr_req = 1'b1;
      frames(1, H_ACT);
      frames(3, H_ACT - 1);                                        // geometry change
      frames(3, H_ACT);
      send_frame(H_ACT, V_ACT, 1'b1, -1, -1, 1'b0, 1'b0, -1);      // vs/hs/de coincide
      frames(3, H_ACT);
      send_stretch(4100);                                          // missing vs
      frames(3, H_ACT);
      send_frame(H_ACT, V_ACT, 1'b0, -1, -1, 1'b0, 1'b0, 5);       // reset mid-frame
      frames(4, H_ACT);
      repeat (3) tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
